// File: rtl/display_bcm_driver.sv
// HUB75-style scan controller with binary-coded modulation: shift, latch and brightness-scaled dwell per bit-plane.
// Define DISPLAY_BCM_FRAME_COUNT_EN to add a 16-bit frame_count output.
module display_bcm_driver #(
  parameter int ROWS       = 16,
  parameter int COLUMNS    = 64,
  parameter int BITS       = 8,
  parameter int BASE_DWELL = 8,
  parameter int ROW_BLANK  = 4,
  parameter int PIPE       = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       enable,
  input  logic [7:0]                                 brightness,
  input  logic                                       flip_req,
  output logic                                       flip_ack,
  output logic                                       frame_start,
  output logic [$clog2(ROWS)-1:0]                    row,
  output logic [$clog2(COLUMNS)-1:0]                 column,
  output logic [((BITS > 1) ? $clog2(BITS) : 1)-1:0] plane,
  output logic                                       oclk,
  output logic                                       lat,
  output logic                                       oe,
  output logic                                       busy
`ifdef DISPLAY_BCM_FRAME_COUNT_EN
  ,
  output logic [15:0]                                frame_count
`endif
);

  localparam int RW       = $clog2(ROWS);
  localparam int CLW      = $clog2(COLUMNS);
  localparam int PW       = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int MW       = $clog2(BASE_DWELL) + BITS + 8;
  localparam int SCAN_LEN = PIPE + 2 * COLUMNS;
  localparam int CW0      = (MW > $clog2(SCAN_LEN + 1)) ? MW : $clog2(SCAN_LEN + 1);
  localparam int CW       = (CW0 > $clog2(ROW_BLANK + 1)) ? CW0 : $clog2(ROW_BLANK + 1);

  localparam logic [CW-1:0] ADDR_LAST  = CW'(PIPE - 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_LEN - 1);
  localparam logic [CW-1:0] COL_END    = CW'(2 * COLUMNS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(ROW_BLANK - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(BITS - 1);
  localparam logic          PIPE_ODD   = 1'(PIPE % 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_SHIFT, S_LATCH, S_SHOW, S_BLANK, S_NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   on_q, on_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [CLW-1:0]  column_q, column_d;
  logic            oclk_q, oclk_d;
  logic            lat_q, lat_d;
  logic            oe_q, oe_d;
  logic            flip_ack_q, flip_ack_d;
  logic            frame_start_q, frame_start_d;
  logic            busy_q, busy_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [CW-1:0]   window;
  logic [MW-1:0]   product;
  logic            end_of_frame;

  always_comb begin
    window       = CW'(BASE_DWELL) << plane_q;
    product      = MW'(window) * (MW'(brightness) + MW'(1));
    end_of_frame = (row_q == ROW_LAST) && (plane_q == PLANE_LAST);

    state_d       = state_q;
    cnt_d         = cnt_q + CW'(1);
    on_d          = on_q;
    row_d         = row_q;
    plane_d       = plane_q;
    flip_ack_d    = 1'b0;
    frame_count_d = frame_count_q;

    // ADDR and SHIFT share one counter so column can run ahead of oclk across the boundary.
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (cnt_q == ADDR_LAST) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == SCAN_LAST) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end
      end
      S_LATCH: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          on_d    = CW'(product >> 8);
        end
      end
      S_SHOW: begin
        if (cnt_q == window - CW'(1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_NEXT;
          cnt_d   = '0;
          if (plane_q == PLANE_LAST) begin
            plane_d = '0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end else begin
            plane_d = plane_q + PW'(1);
          end
          if (end_of_frame) begin
            flip_ack_d    = flip_req;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (enable) begin
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
          row_d   = '0;
          plane_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from the next state so the registered copies line up with the state.
    busy_d        = (state_d != S_IDLE);
    frame_start_d = (state_d == S_ADDR) && (state_q != S_ADDR) && (row_d == '0) && (plane_d == '0);
    column_d      = ((state_d == S_ADDR || state_d == S_SHIFT) && (cnt_d < COL_END)) ? cnt_d[CLW:1] : '0;
    oclk_d        = (state_d == S_SHIFT) && (cnt_d[0] == PIPE_ODD);
    lat_d         = !((state_d == S_LATCH) && (cnt_d == '0));
    oe_d          = !((state_d == S_SHOW) && (cnt_d < on_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      on_q          <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      column_q      <= '0;
      oclk_q        <= 1'b0;
      lat_q         <= 1'b1;
      oe_q          <= 1'b1;
      flip_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      on_q          <= on_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      column_q      <= column_d;
      oclk_q        <= oclk_d;
      lat_q         <= lat_d;
      oe_q          <= oe_d;
      flip_ack_q    <= flip_ack_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign row         = row_q;
  assign column      = column_q;
  assign plane       = plane_q;
  assign oclk        = oclk_q;
  assign lat         = lat_q;
  assign oe          = oe_q;
  assign flip_ack    = flip_ack_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

`ifdef DISPLAY_BCM_FRAME_COUNT_EN
  assign frame_count = frame_count_q;
`else
  logic unused_frame_count;
  assign unused_frame_count = ^frame_count_q;
`endif

endmodule

// File: tb/tb_display_bcm_driver.sv
// Directed bench for display_bcm_driver with a small scan configuration (2 rows, 4 columns, 2 planes).
module tb_display_bcm_driver;

  localparam int ROWS       = 2;
  localparam int COLUMNS    = 4;
  localparam int BITS       = 2;
  localparam int BASE_DWELL = 8;
  localparam int ROW_BLANK  = 2;
  localparam int PIPE       = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] brightness = 8'd255;
  logic       flip_req = 1'b0;
  logic       flip_ack, frame_start, oclk, lat, oe, busy;
  logic [0:0] row;
  logic [1:0] column;
  logic [0:0] plane;
`ifdef DISPLAY_BCM_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  display_bcm_driver #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .BITS(BITS),
    .BASE_DWELL(BASE_DWELL), .ROW_BLANK(ROW_BLANK), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
    .flip_req(flip_req), .flip_ack(flip_ack), .frame_start(frame_start),
    .row(row), .column(column), .plane(plane),
    .oclk(oclk), .lat(lat), .oe(oe), .busy(busy)
`ifdef DISPLAY_BCM_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-frame statistics gathered by run_frame.
  int f_len, f_oe0, f_oe1, f_rise, f_lat, f_latbad, f_viol, f_acks, f_ack_idx;
  int f_pchg[4];
  int f_npchg;
  int f_rchg[2];
  int f_nrchg;
  int col_tr[10];
  int ock_tr[10];
  int exp_col[10]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int exp_oclk[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input string tag);
    for (int i = 0; i < 400; i++) begin
      step();
      if (frame_start) return;
    end
    check(tag, 0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_row"}, int'(row), 0);
    check({tag, "_column"}, int'(column), 0);
    check({tag, "_plane"}, int'(plane), 0);
    check({tag, "_oclk"}, int'(oclk), 0);
    check({tag, "_lat"}, int'(lat), 1);
    check({tag, "_oe"}, int'(oe), 1);
    check({tag, "_flip_ack"}, int'(flip_ack), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Called with frame_start just sampled (index 0); runs until the next frame_start.
  task automatic run_frame(input int raise_at, input int drop_at);
    logic prev_oclk, prev_row, prev_plane;
    int rises_plane;
    f_len = 0; f_oe0 = 0; f_oe1 = 0; f_rise = 0; f_lat = 0; f_latbad = 0;
    f_viol = 0; f_acks = 0; f_ack_idx = -1; f_npchg = 0; f_nrchg = 0;
    for (int k = 0; k < 4; k++) f_pchg[k] = -1;
    for (int k = 0; k < 2; k++) f_rchg[k] = -1;
    col_tr[0] = int'(column);
    ock_tr[0] = int'(oclk);
    prev_oclk = oclk; prev_row = row; prev_plane = plane;
    rises_plane = 0;
    for (int idx = 1; idx < 400; idx++) begin
      step();
      if (frame_start) begin
        f_len = idx;
        break;
      end
      if (idx < 10) begin
        col_tr[idx] = int'(column);
        ock_tr[idx] = int'(oclk);
      end
      if (!oe) begin
        if (plane == 1'b0) f_oe0++;
        else f_oe1++;
        if (!lat || oclk != prev_oclk || row != prev_row) f_viol++;
      end
      if (oclk && !prev_oclk) begin
        f_rise++;
        rises_plane++;
      end
      if (!lat) begin
        f_lat++;
        if (rises_plane != COLUMNS || oclk) f_latbad++;
        rises_plane = 0;
      end
      if (plane != prev_plane && f_npchg < 4) begin
        f_pchg[f_npchg] = idx;
        f_npchg++;
      end
      if (row != prev_row && f_nrchg < 2) begin
        f_rchg[f_nrchg] = idx;
        f_nrchg++;
      end
      if (flip_ack) begin
        f_acks++;
        f_ack_idx = idx;
      end
      prev_oclk = oclk; prev_row = row; prev_plane = plane;
      if (idx == raise_at) flip_req = 1'b1;
      if (idx == drop_at) flip_req = 1'b0;
    end
    $display("[TB] frame len=%0d oe0=%0d oe1=%0d rises=%0d lat=%0d acks=%0d bright=%0d",
             f_len, f_oe0, f_oe1, f_rise, f_lat, f_acks, brightness);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int total_acks;
    int idle_idx;

    repeat (3) step();
    check_reset_values("reset");
`ifdef DISPLAY_BCM_FRAME_COUNT_EN
    check("reset_frame_count", int'(frame_count), 0);
`endif

    // Free run at full brightness.
    rst = 1'b0;
    enable = 1'b1;
    brightness = 8'd255;
    wait_fs("fs_first");
    run_frame(-1, -1);
    check("b255_len", f_len, 108);
    check("b255_oe0", f_oe0, 16);
    check("b255_oe1", f_oe1, 32);
    check("b255_rises", f_rise, 16);
    check("b255_lat", f_lat, 4);
    check("b255_latbad", f_latbad, 0);
    check("b255_oe_viol", f_viol, 0);
    check("b255_pchg0", f_pchg[0], 22);
    check("b255_pchg1", f_pchg[1], 53);
    check("b255_pchg2", f_pchg[2], 76);
    check("b255_pchg3", f_pchg[3], 107);
    check("b255_rchg0", f_rchg[0], 53);
    check("b255_rchg1", f_rchg[1], 107);
    check("b255_acks", f_acks, 0);
    for (int t = 0; t < 10; t++) begin
      check($sformatf("column_t%0d", t), col_tr[t], exp_col[t]);
      check($sformatf("oclk_t%0d", t), ock_tr[t], exp_oclk[t]);
    end

    brightness = 8'd127;
    run_frame(-1, -1);
    check("b127_len", f_len, 108);
    check("b127_oe0", f_oe0, 8);
    check("b127_oe1", f_oe1, 16);
    check("b127_oe_viol", f_viol, 0);

    brightness = 8'd0;
    run_frame(-1, -1);
    check("b0_len", f_len, 108);
    check("b0_oe0", f_oe0, 0);
    check("b0_oe1", f_oe1, 0);

    // Flip handshake.
    brightness = 8'd255;
    run_frame(30, -1);
    check("flip_acks", f_acks, 1);
    check("flip_ack_idx", f_ack_idx, 107);
    total_acks = 0;
    for (int fr = 0; fr < 3; fr++) begin
      run_frame(-1, -1);
      total_acks += f_acks;
    end
    check("flip_held_acks", total_acks, 3);
    flip_req = 1'b0;
    run_frame(-1, -1);
    check("flip_low_acks", f_acks, 0);
    run_frame(30, 60);
    check("flip_dropped_acks", f_acks, 0);

    // Drop enable mid-dwell of row 0 plane 0.
    for (int idx = 1; idx <= 15; idx++) step();
    enable = 1'b0;
    idle_idx = -1;
    for (int idx = 16; idx < 200; idx++) begin
      step();
      if (!busy) begin
        idle_idx = idx;
        break;
      end
    end
    check("idle_idx", idle_idx, 23);
    check("idle_oe", int'(oe), 1);
    check("idle_row", int'(row), 0);
    check("idle_plane", int'(plane), 0);
    repeat (5) step();
    check("idle_busy_hold", int'(busy), 0);
    check("idle_oe_hold", int'(oe), 1);
    enable = 1'b1;
    step();
    check("reenable_fs", int'(frame_start), 1);
    check("reenable_row", int'(row), 0);
    check("reenable_plane", int'(plane), 0);
    check("reenable_busy", int'(busy), 1);

    // Reset in the middle of SHIFT.
    repeat (5) step();
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    step();
    check_reset_values("rst_shift");
    rst = 1'b0;
`ifdef DISPLAY_BCM_FRAME_COUNT_EN
    check("rst_frame_count", int'(frame_count), 0);
`endif
    wait_fs("fs_after_rst");
    for (int fr = 0; fr < 3; fr++) run_frame(-1, -1);
    check("post_rst_len", f_len, 108);
`ifdef DISPLAY_BCM_FRAME_COUNT_EN
    check("frame_count_3", int'(frame_count), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
